// File: rtl/and4_sweep_ctrl_if.sv
// Handshake and result bundle between the sweep controller and the gate under test.
// master = controller side, slave = gate/host side.
interface and4_sweep_ctrl_if #(
    parameter int unsigned N_IN = 4
);
    logic            start;
    logic [N_IN-1:0] pat_o;
    logic            dut_f_i;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] fail_pat;

    modport master (
        input  start,
        input  dut_f_i,
        output pat_o,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_pat
    );

    modport slave (
        output start,
        output dut_f_i,
        input  pat_o,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_pat
    );
endinterface

// File: rtl/and4_sweep_ctrl.sv
// Exhaustive self-checking sweep sequencer for an N_IN-input AND gate.
// Optional macro SWEEP_GRAY_EN: drive the Gray code of the pattern index instead of binary.
module and4_sweep_ctrl #(
    parameter int unsigned N_IN        = 4,
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    and4_sweep_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [7:0]      HoldLast = 8'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] IdxOne   = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   ErrOne   = {{N_IN{1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [7:0]      hold_q, hold_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fail_q, fail_d;
    logic            first_q, first_d;
    logic            pass_q, pass_d;

    logic [N_IN-1:0] pat;
    logic            sample;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    always_comb begin
`ifdef SWEEP_GRAY_EN
        pat = idx_q ^ (idx_q >> 1);
`else
        pat = idx_q;
`endif
    end

    assign sample   = (state_q == StRun) && (hold_q == HoldLast);
    assign mismatch = sample && (bus.dut_f_i != (&pat));
    assign err_next = mismatch ? (err_q + ErrOne) : err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        err_d   = err_q;
        fail_d  = fail_q;
        first_d = first_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    idx_d   = '0;
                    hold_d  = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    first_d = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StRun: begin
                if (sample) begin
                    hold_d = '0;
                    err_d  = err_next;
                    // Only the first mismatching pattern is latched.
                    if (mismatch && !first_q) begin
                        fail_d  = pat;
                        first_d = 1'b1;
                    end
                    if (idx_q == '1) begin
                        state_d = StDone;
                        idx_d   = '0;
                        pass_d  = (err_next == '0);
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            first_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs decode straight from state so reset clears them without an extra cycle.
    assign bus.pat_o    = (state_q == StRun) ? pat : '0;
    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_pat = fail_q;

endmodule

// File: tb/tb_and4_sweep_ctrl.sv
// Directed self-checking bench for and4_sweep_ctrl: good gate, stuck-at faults,
// missing input, mid-sweep reset, ignored restart, restart from DONE, HOLD_CYCLES = 1.
module tb_and4_sweep_ctrl;

    localparam int unsigned N_IN = 4;

    logic clk;
    logic rst_n;
    int   mode;      // 0 good AND, 1 stuck-at-0, 2 stuck-at-1, 3 a&b&c only
    int   n_cmp;
    int   n_err;

    and4_sweep_ctrl_if #(.N_IN(N_IN)) bus ();
    and4_sweep_ctrl_if #(.N_IN(N_IN)) bus1 ();

    and4_sweep_ctrl #(.N_IN(N_IN), .HOLD_CYCLES(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    and4_sweep_ctrl #(.N_IN(N_IN), .HOLD_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    assign bus.dut_f_i = (mode == 1) ? 1'b0 :
                         (mode == 2) ? 1'b1 :
                         (mode == 3) ? (bus.pat_o[0] & bus.pat_o[1] & bus.pat_o[2]) :
                                       (&bus.pat_o);
    assign bus1.dut_f_i = &bus1.pat_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat_of(input int i);
        logic [31:0] v;
        v = 32'(i);
`ifdef SWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    task automatic start_sweep(input string tag);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        check({tag, "_done_clr"},  32'(bus.done), 32'd0);
        check({tag, "_err_clr"},   32'(bus.err_cnt), 32'd0);
    endtask

    // Count cycles from the start edge until done, optionally checking pat_o each cycle.
    task automatic wait_done(input string tag, input int restart_at, input bit chk_pat);
        int cycles;
        cycles = 0;
        while (!bus.done && cycles < 200) begin
            if (chk_pat) check({tag, "_pat"}, 32'(bus.pat_o), pat_of(cycles / 5));
            bus.start = (cycles == restart_at);
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(cycles), 32'd80);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_pat_end"}, 32'(bus.pat_o), 32'd0);
    endtask

    task automatic check_result(input string tag, input int err, input int fpat, input int ok);
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(err));
        check({tag, "_fail_pat"}, 32'(bus.fail_pat), 32'(fpat));
        check({tag, "_pass"}, 32'(bus.pass), 32'(ok));
    endtask

    initial begin
        int cycles;
        n_cmp      = 0;
        n_err      = 0;
        mode       = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_pat", 32'(bus.pat_o), 32'd0);
        check("rst_err", 32'(bus.err_cnt), 32'd0);
        check("rst_fail", 32'(bus.fail_pat), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        mode = 0;
        start_sweep("good");
        wait_done("good", -1, 1'b1);
        check_result("good", 0, 0, 1);
        repeat (3) @(negedge clk);
        check("done_hold", 32'(bus.done), 32'd1);

        mode = 1;
        start_sweep("sa0");
        wait_done("sa0", -1, 1'b0);
        check_result("sa0", 1, 'hF, 0);

        // Restart from DONE must clear the previous nonzero err_cnt.
        mode = 2;
        start_sweep("sa1");
        wait_done("sa1", -1, 1'b0);
        check_result("sa1", 15, 0, 0);

        mode = 3;
        start_sweep("abc");
        wait_done("abc", -1, 1'b0);
        check_result("abc", 1, 'h7, 0);

        mode = 0;
        start_sweep("restart");
        wait_done("restart", 10, 1'b1);
        check_result("restart", 0, 0, 1);

        mode = 2;
        start_sweep("abort");
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_pat", 32'(bus.pat_o), 32'd0);
        check("abort_err", 32'(bus.err_cnt), 32'd0);
        check("abort_fail", 32'(bus.fail_pat), 32'd0);
        check("abort_pass", 32'(bus.pass), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        mode = 0;
        start_sweep("after_abort");
        wait_done("after_abort", -1, 1'b0);
        check_result("after_abort", 0, 0, 1);

        @(negedge clk) bus1.start = 1'b1;
        @(negedge clk) bus1.start = 1'b0;
        check("h1_busy", 32'(bus1.busy), 32'd1);
        cycles = 0;
        while (!bus1.done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("h1_latency", 32'(cycles), 32'd16);
        check("h1_pass", 32'(bus1.pass), 32'd1);
        check("h1_err", 32'(bus1.err_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
